// File: rtl/cacheline_burst_adaptor.sv
// Bridges a 256-bit cacheline pmem port onto a narrow sequential burst port.
// Each line transfer becomes BEATS beats, lowest slice first, then a one-cycle pmem_resp.
module cacheline_burst_adaptor #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pmem_addr,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic [31:0]          burst_addr,
  output logic                 burst_read,
  output logic                 burst_write,
  output logic [BEAT_BITS-1:0] burst_wdata,
  input  logic [BEAT_BITS-1:0] burst_rdata,
  input  logic                 burst_resp
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_BITS / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]     beat_inc;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic [31:0]          addr_q, addr_d;
  logic                 resp_q, resp_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [BEAT_BITS-1:0] wdata_q, wdata_d;

  // line_q doubles as the write-data snapshot and the read assembly buffer;
  // rdata_q is only refreshed on the final read beat so pmem_rdata stays stable.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    beat_inc = beat_q + 1'b1;
    line_d   = line_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    resp_d   = 1'b0;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (pmem_write) begin
          line_d  = pmem_wdata;
          addr_d  = pmem_addr & ALIGN_MASK;
          wdata_d = pmem_wdata[BEAT_BITS-1:0];
          wr_d    = 1'b1;
          state_d = WR;
        end else if (pmem_read) begin
          addr_d  = pmem_addr & ALIGN_MASK;
          rd_d    = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (burst_resp) begin
          line_d[int'(beat_q)*BEAT_BITS +: BEAT_BITS] = burst_rdata;
          if (beat_q == LAST_BEAT) begin
            rdata_d = line_d;
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            beat_d = beat_inc;
          end
        end
      end
      WR: begin
        if (burst_resp) begin
          if (beat_q == LAST_BEAT) begin
            wr_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            beat_d  = beat_inc;
            wdata_d = line_q[int'(beat_inc)*BEAT_BITS +: BEAT_BITS];
          end
        end
      end
      RESP: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pmem_rdata  = rdata_q;
  assign pmem_resp   = resp_q;
  assign burst_addr  = addr_q;
  assign burst_read  = rd_q;
  assign burst_write = wr_q;
  assign burst_wdata = wdata_q;

endmodule
